// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags. Dispatch reads are
// combinational (0 cycles) with commit bypass. All state holds while rdy is low.
module regfile_rename #(
    parameter int REG_NUM = 32,
    parameter int NAME_W  = 5,
    parameter int NICK_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iCLR,
    input  logic              iROB_nick_en,
    input  logic [NICK_W-1:0] iROB_nick,
    input  logic [NAME_W-1:0] iROB_nick_regnm,
    input  logic              iROB_en,
    input  logic [NAME_W-1:0] iROB_rd_regnm,
    input  logic [DATA_W-1:0] iROB_rd_dt,
    input  logic [NICK_W-1:0] iROB_rd_nick,
    input  logic [NAME_W-1:0] iDP_rs1_regnm,
    input  logic [NAME_W-1:0] iDP_rs2_regnm,
    output logic [DATA_W-1:0] oDP_rs1_dt,
    output logic [NICK_W-1:0] oDP_rs1_nick,
    output logic [DATA_W-1:0] oDP_rs2_dt,
    output logic [NICK_W-1:0] oDP_rs2_nick,
    output logic [5:0]        oBUSY_cnt
);

    logic [DATA_W-1:0] r_data [REG_NUM];
    logic [NICK_W-1:0] r_nick [REG_NUM];
    logic [5:0]        r_busy_cnt;

    logic [NICK_W-1:0] w_nick_nxt [REG_NUM];
    logic [5:0]        w_busy_nxt;
    logic              w_commit;
    logic              w_rename;

    logic [NAME_W-1:0] w_rs      [2];
    logic [DATA_W-1:0] w_rd_dt   [2];
    logic [NICK_W-1:0] w_rd_nick [2];

    assign w_commit = iROB_en && (iROB_rd_regnm != '0);
    // Nick 0 means "no producer", so a rename carrying it is meaningless and dropped.
    assign w_rename = iROB_nick_en && !iCLR && (iROB_nick_regnm != '0) && (iROB_nick != '0);

    // Rename beats a matching commit on the same register; clear beats both.
    always_comb begin
        w_busy_nxt = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            w_nick_nxt[i] = r_nick[i];
            if (i == 0 || iCLR) begin
                w_nick_nxt[i] = '0;
            end else if (w_rename && (iROB_nick_regnm == NAME_W'(i))) begin
                w_nick_nxt[i] = iROB_nick;
            end else if (w_commit && (iROB_rd_regnm == NAME_W'(i)) &&
                         (r_nick[i] == iROB_rd_nick)) begin
                w_nick_nxt[i] = '0;
            end
            if (w_nick_nxt[i] != '0) begin
                w_busy_nxt = w_busy_nxt + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_data[i] <= '0;
                r_nick[i] <= '0;
            end
            r_busy_cnt <= '0;
        end else if (rdy) begin
            if (w_commit) begin
                r_data[iROB_rd_regnm] <= iROB_rd_dt;
            end
            for (int i = 0; i < REG_NUM; i++) begin
                r_nick[i] <= w_nick_nxt[i];
            end
            r_busy_cnt <= w_busy_nxt;
        end
    end

    assign w_rs[0] = iDP_rs1_regnm;
    assign w_rs[1] = iDP_rs2_regnm;

    // Reads look only at current state plus the commit port, never at a same-cycle rename.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_dt[p]   = r_data[w_rs[p]];
            w_rd_nick[p] = r_nick[w_rs[p]];
            if (w_rs[p] == '0) begin
                w_rd_dt[p]   = '0;
                w_rd_nick[p] = '0;
            end else if ((r_nick[w_rs[p]] != '0) && iROB_en &&
                         (iROB_rd_regnm == w_rs[p]) &&
                         (iROB_rd_nick == r_nick[w_rs[p]])) begin
                w_rd_dt[p]   = iROB_rd_dt;
                w_rd_nick[p] = '0;
            end
        end
    end

    assign oDP_rs1_dt   = w_rd_dt[0];
    assign oDP_rs1_nick = w_rd_nick[0];
    assign oDP_rs2_dt   = w_rd_dt[1];
    assign oDP_rs2_nick = w_rd_nick[1];
    assign oBUSY_cnt    = r_busy_cnt;

endmodule

// File: tb/tb_regfile_rename.sv
// Randomised and directed stimulus for regfile_rename, checked through a scoreboard
// fed by a register-file reference model.
module tb_regfile_rename;

    logic        clk = 1'b0;
    logic        rst, rdy, iCLR, iROB_nick_en, iROB_en;
    logic [4:0]  iROB_nick, iROB_nick_regnm, iROB_rd_regnm, iROB_rd_nick;
    logic [31:0] iROB_rd_dt;
    logic [4:0]  iDP_rs1_regnm, iDP_rs2_regnm;
    logic [31:0] oDP_rs1_dt, oDP_rs2_dt;
    logic [4:0]  oDP_rs1_nick, oDP_rs2_nick;
    logic [5:0]  oBUSY_cnt;

    always #5 clk = ~clk;

    regfile_rename dut (
        .clk(clk), .rst(rst), .rdy(rdy), .iCLR(iCLR),
        .iROB_nick_en(iROB_nick_en), .iROB_nick(iROB_nick), .iROB_nick_regnm(iROB_nick_regnm),
        .iROB_en(iROB_en), .iROB_rd_regnm(iROB_rd_regnm), .iROB_rd_dt(iROB_rd_dt),
        .iROB_rd_nick(iROB_rd_nick),
        .iDP_rs1_regnm(iDP_rs1_regnm), .iDP_rs2_regnm(iDP_rs2_regnm),
        .oDP_rs1_dt(oDP_rs1_dt), .oDP_rs1_nick(oDP_rs1_nick),
        .oDP_rs2_dt(oDP_rs2_dt), .oDP_rs2_nick(oDP_rs2_nick),
        .oBUSY_cnt(oBUSY_cnt)
    );

    typedef struct {
        logic [31:0] d1;
        logic [4:0]  n1;
        logic [31:0] d2;
        logic [4:0]  n2;
        logic [5:0]  busy;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_data [32];
    logic [4:0]  m_nick [32];

    function automatic int busy_count();
        int c = 0;
        for (int i = 1; i < 32; i++) if (m_nick[i] != 0) c++;
        return c;
    endfunction

    function automatic void model_read(input logic [4:0] rs, output logic [31:0] d,
                                       output logic [4:0] n);
        d = m_data[rs];
        n = m_nick[rs];
        if (rs == 0) begin
            d = 0;
            n = 0;
        end else if (m_nick[rs] != 0 && iROB_en && iROB_rd_regnm == rs &&
                     iROB_rd_nick == m_nick[rs]) begin
            d = iROB_rd_dt;
            n = 0;
        end
    endfunction

    task automatic step(input logic rst_v, input logic rdy_v, input logic clr,
                        input logic ne, input logic [4:0] nk, input logic [4:0] nrg,
                        input logic ce, input logic [4:0] crg, input logic [31:0] cdt,
                        input logic [4:0] cnk, input logic [4:0] s1, input logic [4:0] s2);
        exp_t e;
        rst = rst_v; rdy = rdy_v; iCLR = clr;
        iROB_nick_en = ne; iROB_nick = nk; iROB_nick_regnm = nrg;
        iROB_en = ce; iROB_rd_regnm = crg; iROB_rd_dt = cdt; iROB_rd_nick = cnk;
        iDP_rs1_regnm = s1; iDP_rs2_regnm = s2;
        if (!rst_v) begin
            for (int i = 0; i < 32; i++) begin
                m_data[i] = 0;
                m_nick[i] = 0;
            end
        end
        model_read(s1, e.d1, e.n1);
        model_read(s2, e.d2, e.n2);
        e.busy = 6'(busy_count());
        sbq.push_back(e);
        @(posedge clk);
        if (rst_v && rdy_v) begin
            if (ce && crg != 0) m_data[crg] = cdt;
            if (clr) begin
                for (int i = 0; i < 32; i++) m_nick[i] = 0;
            end else begin
                if (ce && crg != 0 && m_nick[crg] == cnk) m_nick[crg] = 0;
                if (ne && nrg != 0 && nk != 0) m_nick[nrg] = nk;
            end
        end
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("rs1_nick", 32'(oDP_rs1_nick), 32'(e.n1));
                if (e.n1 == 0) chk("rs1_dt", oDP_rs1_dt, e.d1);
                chk("rs2_nick", 32'(oDP_rs2_nick), 32'(e.n2));
                if (e.n2 == 0) chk("rs2_dt", oDP_rs2_dt, e.d2);
                chk("busy_cnt", 32'(oBUSY_cnt), 32'(e.busy));
            end
        end
    end

    initial begin
        logic [4:0] r, c;
        rst = 0; rdy = 1; iCLR = 0; iROB_nick_en = 0; iROB_nick = 0; iROB_nick_regnm = 0;
        iROB_en = 0; iROB_rd_regnm = 0; iROB_rd_dt = 0; iROB_rd_nick = 0;
        iDP_rs1_regnm = 0; iDP_rs2_regnm = 0;
        @(posedge clk);
        #1;
        //   rst rdy clr ne nk     nrg    ce crg    cdt            cnk    s1     s2
        step(0,  1,  0,  0, 5'd0,  5'd0,  0, 5'd0,  32'h0,         5'd0,  5'd5,  5'd0);
        step(1,  1,  0,  0, 5'd0,  5'd0,  0, 5'd0,  32'h0,         5'd0,  5'd5,  5'd0);
        step(1,  1,  0,  0, 5'd0,  5'd0,  1, 5'd5,  32'hDEADBEEF,  5'd3,  5'd5,  5'd7);
        step(1,  1,  0,  1, 5'd4,  5'd7,  0, 5'd0,  32'h0,         5'd0,  5'd5,  5'd7);
        step(1,  1,  0,  0, 5'd0,  5'd0,  1, 5'd7,  32'h55,        5'd4,  5'd7,  5'd5);
        step(1,  1,  0,  1, 5'd4,  5'd7,  0, 5'd0,  32'h0,         5'd0,  5'd7,  5'd7);
        step(1,  1,  0,  1, 5'd9,  5'd7,  0, 5'd0,  32'h0,         5'd0,  5'd7,  5'd0);
        step(1,  1,  0,  0, 5'd0,  5'd0,  1, 5'd7,  32'h11,        5'd4,  5'd7,  5'd0);
        step(1,  1,  0,  1, 5'd2,  5'd8,  0, 5'd0,  32'h0,         5'd0,  5'd7,  5'd8);
        step(1,  1,  0,  1, 5'd6,  5'd8,  1, 5'd8,  32'h22,        5'd2,  5'd8,  5'd7);
        step(1,  1,  0,  1, 5'd11, 5'd1,  0, 5'd0,  32'h0,         5'd0,  5'd8,  5'd8);
        step(1,  1,  0,  1, 5'd12, 5'd2,  0, 5'd0,  32'h0,         5'd0,  5'd1,  5'd7);
        step(1,  1,  0,  1, 5'd13, 5'd3,  0, 5'd0,  32'h0,         5'd0,  5'd2,  5'd8);
        step(1,  1,  1,  1, 5'd10, 5'd4,  1, 5'd6,  32'h66,        5'd0,  5'd3,  5'd4);
        step(1,  1,  0,  1, 5'd14, 5'd0,  1, 5'd0,  32'hFFFF,      5'd0,  5'd4,  5'd6);
        step(1,  1,  0,  0, 5'd0,  5'd0,  0, 5'd0,  32'h0,         5'd0,  5'd0,  5'd0);
        step(1,  0,  0,  1, 5'd15, 5'd9,  1, 5'd9,  32'h99,        5'd0,  5'd9,  5'd5);
        step(1,  1,  0,  0, 5'd0,  5'd0,  0, 5'd0,  32'h0,         5'd0,  5'd9,  5'd5);
        step(1,  1,  0,  1, 5'd16, 5'd5,  0, 5'd0,  32'h0,         5'd0,  5'd5,  5'd8);
        step(0,  0,  0,  0, 5'd0,  5'd0,  0, 5'd0,  32'h0,         5'd0,  5'd5,  5'd8);
        step(1,  1,  0,  0, 5'd0,  5'd0,  0, 5'd0,  32'h0,         5'd0,  5'd5,  5'd8);
        for (int k = 0; k < 600; k++) begin
            r = 5'($urandom_range(0, 9));
            c = 5'($urandom_range(0, 9));
            step(($urandom_range(0, 150) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 40) == 0), ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 31)), r,
                 ($urandom_range(0, 1) == 1), c, $urandom(),
                 ($urandom_range(0, 3) != 0) ? m_nick[c] : 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 9)), ($urandom_range(0, 1) == 1) ? c : r);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
